// File: rtl/tl_ram.sv
// TileLink-UL single-port RAM responder.
// One request is in flight at most. The flow is IDLE (accept) -> ACCESS
// (storage read/write) -> RESP (hold the D beat until it is taken).
// Storage contents survive reset. Only control and response outputs are cleared.
module tl_ram #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  // A channel
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [2:0]  a_size,
  input  logic [3:0]  a_source,
  input  logic [63:0] a_address,
  input  logic [7:0]  a_mask,
  input  logic [63:0] a_data,
  input  logic        a_corrupt,
  input  logic        a_valid,
  output logic        a_ready,
  // D channel
  output logic [2:0]  d_opcode,
  output logic [1:0]  d_param,
  output logic [2:0]  d_size,
  output logic [3:0]  d_source,
  output logic [5:0]  d_sink,
  output logic        d_denied,
  output logic [63:0] d_data,
  output logic        d_corrupt,
  output logic        d_valid,
  input  logic        d_ready
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;

  // Captured request (stage p0).
  logic [2:0]  opcode_p0;
  logic [2:0]  size_p0;
  logic [3:0]  source_p0;
  logic [63:0] addr_p0;
  logic [7:0]  mask_p0;
  logic [63:0] data_p0;
  logic        corrupt_p0;

  // Decode of the captured request.
  logic [63:0]      offset_p0;
  logic [IDX_W-1:0] idx_p0;
  logic             is_get_p0;
  logic             is_put_p0;
  logic             denied_p0;

  logic [63:0] mem [DEPTH];

  // a_param carries no meaning for the accesses this RAM serves.
  logic unused_a_param;
  assign unused_a_param = ^a_param;

  // Low address bits must be zero for the requested transfer size.
  function automatic logic misaligned(input logic [2:0] size, input logic [2:0] lsb);
    logic r;
    case (size)
      3'd1:    r = lsb[0];
      3'd2:    r = |lsb[1:0];
      3'd3:    r = |lsb[2:0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Request is refused for unsupported opcodes, out-of-window addresses,
  // illegal or misaligned sizes, and corrupt write data.
  function automatic logic req_denied(input logic [2:0]  op,
                                      input logic [2:0]  size,
                                      input logic [63:0] addr,
                                      input logic [63:0] offset,
                                      input logic        corrupt);
    logic supported;
    logic is_put;
    logic out_of_range;
    supported    = (op == OP_GET) || (op == OP_PUT_FULL) || (op == OP_PUT_PARTIAL);
    is_put       = (op == OP_PUT_FULL) || (op == OP_PUT_PARTIAL);
    out_of_range = (addr < BASE_ADDR) || (offset >= SPAN);
    return !supported || out_of_range || (size > 3'd3) ||
           misaligned(size, addr[2:0]) || (is_put && corrupt);
  endfunction

  assign a_ready = (state == IDLE) && rst_n;
  assign d_param = 2'd0;
  assign d_sink  = 6'd0;

  // Latch the request fields on the accepting handshake.
  always_ff @(posedge clk) begin
    if (a_valid && (state == IDLE)) begin
      opcode_p0  <= a_opcode;
      size_p0    <= a_size;
      source_p0  <= a_source;
      addr_p0    <= a_address;
      mask_p0    <= a_mask;
      data_p0    <= a_data;
      corrupt_p0 <= a_corrupt;
    end
  end

  // Decode the captured request into word index, kind and denial.
  always_comb begin
    offset_p0 = addr_p0 - BASE_ADDR;
    idx_p0    = offset_p0[IDX_W+2:3];
    is_get_p0 = (opcode_p0 == OP_GET);
    is_put_p0 = (opcode_p0 == OP_PUT_FULL) || (opcode_p0 == OP_PUT_PARTIAL);
    denied_p0 = req_denied(opcode_p0, size_p0, addr_p0, offset_p0, corrupt_p0);
  end

  // Byte-lane masked write of an accepted, non-denied Put.
  always_ff @(posedge clk) begin
    if ((state == ACCESS) && is_put_p0 && !denied_p0) begin
      for (int i = 0; i < 8; i++) begin
        if (mask_p0[i]) begin
          mem[idx_p0][8*i +: 8] <= data_p0[8*i +: 8];
        end
      end
    end
  end

  // Response stage (p1): the state machine that also registers the D beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      d_valid   <= 1'b0;
      d_opcode  <= 3'd0;
      d_size    <= 3'd0;
      d_source  <= 4'd0;
      d_denied  <= 1'b0;
      d_data    <= 64'd0;
      d_corrupt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_valid) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          state     <= RESP;
          d_valid   <= 1'b1;
          d_opcode  <= is_get_p0 ? OP_ACK_DATA : OP_ACK;
          d_size    <= size_p0;
          d_source  <= source_p0;
          d_denied  <= denied_p0;
          d_data    <= (is_get_p0 && !denied_p0) ? mem[idx_p0] : 64'd0;
          d_corrupt <= is_get_p0 && denied_p0;
        end
        RESP: begin
          if (d_ready) begin
            state   <= IDLE;
            d_valid <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          d_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tl_ram.sv
// Randomized bench for tl_ram against an array-based TileLink-UL RAM model.
module tb_tl_ram;

  localparam int unsigned DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  a_opcode = '0, a_param = '0, a_size = '0;
  logic [3:0]  a_source = '0;
  logic [63:0] a_address = '0, a_data = '0;
  logic [7:0]  a_mask = '0;
  logic        a_corrupt = 1'b0, a_valid = 1'b0, a_ready;
  logic [2:0]  d_opcode, d_size;
  logic [1:0]  d_param;
  logic [3:0]  d_source;
  logic [5:0]  d_sink;
  logic        d_denied, d_corrupt, d_valid;
  logic [63:0] d_data;
  logic        d_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] ref_mem [DEPTH];

  tl_ram #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
    .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt),
    .d_valid(d_valid), .d_ready(d_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_denied(input logic [2:0] op, input logic [2:0] sz,
                                        input logic [63:0] addr, input logic cor);
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
    if (addr < BASE) return 1'b1;
    if (addr - BASE >= SPAN) return 1'b1;
    if (sz > 3'd3) return 1'b1;
    if ((addr % (64'd1 << sz)) != 64'd0) return 1'b1;
    if (op != 3'd4 && cor) return 1'b1;
    return 1'b0;
  endfunction

  // One full transaction; hold = cycles d_ready stays low once d_valid is up.
  task automatic txn(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                     input logic [63:0] addr, input logic [7:0] msk, input logic [63:0] dat,
                     input logic cor, input int hold);
    logic        e_den, e_cor, got;
    logic [2:0]  e_op;
    logic [63:0] e_data;
    int          w;
    e_den  = model_denied(op, sz, addr, cor);
    w      = e_den ? 0 : int'((addr - BASE) >> 3);
    e_op   = (op == 3'd4) ? 3'd1 : 3'd0;
    e_cor  = (op == 3'd4) && e_den;
    e_data = ((op == 3'd4) && !e_den) ? ref_mem[w] : 64'd0;

    @(negedge clk);
    a_opcode = op; a_size = sz; a_source = src; a_address = addr;
    a_mask = msk; a_data = dat; a_corrupt = cor; a_param = 3'($urandom);
    a_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (a_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("a_ready_wait", got, 1);
    if (!got) begin
      a_valid = 1'b0;
      return;
    end
    @(negedge clk);
    a_valid = 1'b0;
    chk("d_valid_n1", d_valid, 0);
    @(negedge clk);
    for (int k = 0; k <= hold; k++) begin
      chk("d_valid", d_valid, 1);
      chk("d_opcode", d_opcode, e_op);
      chk("d_denied", d_denied, e_den);
      chk("d_corrupt", d_corrupt, e_cor);
      chk("d_data", d_data, e_data);
      chk("d_size", d_size, sz);
      chk("d_source", d_source, src);
      chk("d_param", d_param, 0);
      chk("d_sink", d_sink, 0);
      chk("a_ready_busy", a_ready, 0);
      if (k == hold) d_ready = 1'b1;
      @(negedge clk);
    end
    d_ready = 1'b0;
    chk("d_valid_done", d_valid, 0);
    chk("a_ready_next", a_ready, 1);

    if (!e_den && (op == 3'd0 || op == 3'd1)) begin
      for (int b = 0; b < 8; b++) begin
        if (msk[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] addr, off;
    logic [2:0]  sz, op;
    int          r, t;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_d_data", d_data, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_release_a_ready", a_ready, 1);

    // Fill the exercised window (first 8 and last 8 words)
    for (int i = 0; i < 16; i++) begin
      r = (i < 8) ? i : int'(DEPTH) - 16 + i;
      txn(3'd0, 3'd3, 4'(i), BASE + 64'(r) * 8, 8'hFF, {$urandom, $urandom}, 1'b0, 0);
    end

    // Write then read
    txn(3'd0, 3'd3, 4'd3, BASE + 64'h10, 8'hFF, 64'h1122334455667788, 1'b0, 0);
    txn(3'd4, 3'd3, 4'd5, BASE + 64'h10, 8'h00, 64'h0, 1'b0, 0);
    // Partial write
    txn(3'd1, 3'd3, 4'd2, BASE + 64'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0, 0);
    txn(3'd4, 3'd3, 4'd6, BASE + 64'h10, 8'h00, 64'h0, 1'b0, 0);
    chk("partial_word", ref_mem[2], 64'h11223344_BBBBBBBB);
    // Backpressure
    txn(3'd4, 3'd3, 4'd7, BASE + 64'h10, 8'hFF, 64'h0, 1'b0, 5);
    // Denied cases
    txn(3'd4, 3'd3, 4'd1, BASE + SPAN, 8'hFF, 64'h0, 1'b0, 0);
    txn(3'd0, 3'd3, 4'd1, BASE + 64'h4, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0, 0);
    txn(3'd4, 3'd3, 4'd1, BASE, 8'hFF, 64'h0, 1'b0, 0);
    txn(3'd4, 3'd3, 4'd1, BASE - 64'h8, 8'hFF, 64'h0, 1'b0, 0);
    txn(3'd0, 3'd3, 4'd9, BASE + 64'h18, 8'hFF, 64'h5555_5555_5555_5555, 1'b1, 1);
    // Unsupported opcode
    txn(3'd3, 3'd3, 4'd4, BASE + 64'h10, 8'hFF, 64'h0, 1'b0, 0);
    txn(3'd4, 3'd3, 4'd4, BASE + 64'h10, 8'hFF, 64'h0, 1'b0, 0);

    // Reset while a Get response is pending
    @(negedge clk);
    a_opcode = 3'd4; a_size = 3'd3; a_source = 4'd8; a_address = BASE + 64'h10;
    a_mask = 8'hFF; a_corrupt = 1'b0; a_valid = 1'b1;
    chk("rr_a_ready", a_ready, 1);
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    chk("rr_d_valid_up", d_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rr_d_valid", d_valid, 0);
    chk("rr_a_ready_low", a_ready, 0);
    chk("rr_d_data", d_data, 0);
    chk("rr_d_opcode", d_opcode, 0);
    chk("rr_d_source", d_source, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rr_a_ready_high", a_ready, 1);
    txn(3'd4, 3'd3, 4'd8, BASE + 64'h10, 8'hFF, 64'h0, 1'b0, 0);

    // Randomized traffic over the window and its edges
    for (int n = 0; n < 300; n++) begin
      t  = int'($urandom_range(0, 19));
      sz = (t < 18) ? 3'(t % 4) : 3'(4 + t % 4);
      r  = int'($urandom_range(0, 15));
      r  = (r < 8) ? r : int'(DEPTH) - 16 + r;
      if ($urandom_range(0, 9) == 0) off = 64'($urandom_range(0, 7));
      else if (sz <= 3'd3) off = 64'(($urandom_range(0, 7) >> sz) << sz);
      else off = 64'd0;
      t = int'($urandom_range(0, 19));
      if (t == 0) addr = BASE - 64'd8 + off;
      else if (t == 1) addr = BASE + SPAN + off;
      else addr = BASE + 64'(r) * 8 + off;
      t = int'($urandom_range(0, 9));
      if (t < 4) op = 3'd4;
      else if (t < 7) op = 3'd0;
      else if (t < 9) op = 3'd1;
      else begin
        op = 3'($urandom_range(2, 7));
        if (op == 3'd4) op = 3'd3;
      end
      txn(op, sz, 4'($urandom), addr, 8'($urandom), {$urandom, $urandom},
          ($urandom_range(0, 9) == 0), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
